// File: rtl/sat_chan_cfg_sched.sv
// Shadow/active configuration bank for the satellite channels.
// Host writes land in shadow registers; a commit moves them to active on the next C/A epoch.
module sat_chan_cfg_sched #(
  parameter int unsigned N_CHAN = 8,
  parameter int unsigned CHAN_W = 4,
  parameter int unsigned CA_MAX = 35
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [CHAN_W-1:0]        wr_chan,
  input  logic [1:0]               wr_field,
  input  logic [31:0]              wr_data,
  input  logic                     commit_req,
  input  logic                     commit_abort,
  input  logic                     epoch,
  output logic                     commit_ack,
  output logic                     busy,
  output logic                     err_sticky,
  input  logic                     err_clr,
  output logic [15:0]              commit_count,
  output logic [N_CHAN-1:0]        chan_enable,
  output logic [32*N_CHAN-1:0]     chan_freq,
  output logic [16*N_CHAN-1:0]     chan_gain,
  output logic [6*N_CHAN-1:0]      chan_ca_sel
);

  localparam int unsigned FREQ_W = 32;
  localparam int unsigned GAIN_W = 16;
  localparam int unsigned CA_W   = 6;
  localparam logic [1:0]  F_FREQ = 2'd0;
  localparam logic [1:0]  F_GAIN = 2'd1;
  localparam logic [1:0]  F_CA   = 2'd2;
  localparam logic [1:0]  F_EN   = 2'd3;

  typedef enum logic {IDLE, ARMED} state_e;

  state_e                           state_q, state_d;
  logic [N_CHAN-1:0][FREQ_W-1:0]    sh_freq_q, sh_freq_d, act_freq_q, act_freq_d;
  logic [N_CHAN-1:0][GAIN_W-1:0]    sh_gain_q, sh_gain_d, act_gain_q, act_gain_d;
  logic [N_CHAN-1:0][CA_W-1:0]      sh_ca_q, sh_ca_d, act_ca_q, act_ca_d;
  logic [N_CHAN-1:0]                sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic                             ack_q, ack_d;
  logic                             err_q, err_d;
  logic [15:0]                      count_q, count_d;

  logic wr_fire_c;
  logic wr_bad_c;

  // Shadow is frozen while a commit is pending, so writes stall in ARMED.
  assign wr_ready  = (state_q == IDLE) & ~rst;
  assign wr_fire_c = wr_valid & wr_ready;
  assign wr_bad_c  = (32'(wr_chan) >= N_CHAN) |
                     ((wr_field == F_CA) && (wr_data[CA_W-1:0] > CA_W'(CA_MAX)));

  always_comb begin
    state_d    = state_q;
    sh_freq_d  = sh_freq_q;
    sh_gain_d  = sh_gain_q;
    sh_ca_d    = sh_ca_q;
    sh_en_d    = sh_en_q;
    act_freq_d = act_freq_q;
    act_gain_d = act_gain_q;
    act_ca_d   = act_ca_q;
    act_en_d   = act_en_q;
    ack_d      = 1'b0;
    err_d      = err_q;
    count_d    = count_q;

    if (wr_fire_c && !wr_bad_c) begin
      for (int i = 0; i < int'(N_CHAN); i++) begin
        if (CHAN_W'(i) == wr_chan) begin
          case (wr_field)
            F_FREQ:  sh_freq_d[i] = wr_data;
            F_GAIN:  sh_gain_d[i] = wr_data[GAIN_W-1:0];
            F_CA:    sh_ca_d[i]   = wr_data[CA_W-1:0];
            F_EN:    sh_en_d[i]   = wr_data[0];
            default: ;
          endcase
        end
      end
    end

    // A new error outranks a simultaneous clear.
    if (wr_fire_c && wr_bad_c) err_d = 1'b1;
    else if (err_clr)          err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (commit_req) state_d = ARMED;
      end
      ARMED: begin
        if (epoch) begin
          act_freq_d = sh_freq_q;
          act_gain_d = sh_gain_q;
          act_ca_d   = sh_ca_q;
          act_en_d   = sh_en_q;
          ack_d      = 1'b1;
          count_d    = count_q + 16'd1;
          state_d    = IDLE;
        end else if (commit_abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_freq_q  <= '0;
      sh_gain_q  <= '0;
      sh_ca_q    <= '0;
      sh_en_q    <= '0;
      act_freq_q <= '0;
      act_gain_q <= '0;
      act_ca_q   <= '0;
      act_en_q   <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      sh_freq_q  <= sh_freq_d;
      sh_gain_q  <= sh_gain_d;
      sh_ca_q    <= sh_ca_d;
      sh_en_q    <= sh_en_d;
      act_freq_q <= act_freq_d;
      act_gain_q <= act_gain_d;
      act_ca_q   <= act_ca_d;
      act_en_q   <= act_en_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  assign busy         = (state_q == ARMED);
  assign commit_ack   = ack_q;
  assign err_sticky   = err_q;
  assign commit_count = count_q;
  assign chan_enable  = act_en_q;
  assign chan_freq    = act_freq_q;
  assign chan_gain    = act_gain_q;
  assign chan_ca_sel  = act_ca_q;

endmodule
